// File: rtl/copro_core.sv
// rtl/copro_core.sv - sequential unsigned multiply/divide engine, one bit per clock
module copro_core #(
    parameter int DATA_WIDTH = 32,
    parameter int CNT_W      = $clog2(DATA_WIDTH)
) (
    input  logic                  ACLK,
    input  logic                  ARESET,
    input  logic                  start,
    input  logic                  done_clr,
    input  logic [1:0]            opcode,
    input  logic [DATA_WIDTH-1:0] op_a,
    input  logic [DATA_WIDTH-1:0] op_b,
    output logic [DATA_WIDTH-1:0] result,
    output logic                  busy,
    output logic                  done,
    output logic                  dbz
);

    localparam logic [1:0] S_IDLE   = 2'd0;
    localparam logic [1:0] S_CALC   = 2'd1;
    localparam logic [1:0] S_FINISH = 2'd2;

    localparam logic [1:0] OP_MUL_LO = 2'b00;
    localparam logic [1:0] OP_MUL_HI = 2'b01;
    localparam logic [1:0] OP_DIV_Q  = 2'b10;
    localparam logic [1:0] OP_DIV_R  = 2'b11;

    localparam logic [CNT_W-1:0] LAST_ITER = CNT_W'(DATA_WIDTH - 1);

    logic [1:0]              state;
    logic [CNT_W-1:0]        cnt;
    logic [DATA_WIDTH-1:0]   a_reg;
    logic [DATA_WIDTH-1:0]   b_reg;
    logic [1:0]              op_reg;
    logic [2*DATA_WIDTH-1:0] prod;
    logic [DATA_WIDTH:0]     rem;
    logic [DATA_WIDTH-1:0]   quo;

    logic [DATA_WIDTH:0]     prod_hi_sum;
    logic [2*DATA_WIDTH-1:0] prod_step;
    logic [DATA_WIDTH+1:0]   rem_sh;
    logic [DATA_WIDTH+1:0]   rem_diff;
    logic                    trial_ok;
    logic [DATA_WIDTH-1:0]   quo_sh;
    logic                    div_by_zero;
    logic [DATA_WIDTH-1:0]   result_next;

    // Shift-add multiply step: conditionally add B into the upper half (carry kept), then shift right
    always_comb begin
        prod_hi_sum = {1'b0, prod[2*DATA_WIDTH-1:DATA_WIDTH]}
                    + (prod[0] ? {1'b0, b_reg} : {(DATA_WIDTH+1){1'b0}});
        prod_step   = {prod_hi_sum, prod[DATA_WIDTH-1:1]};
    end

    // Restoring divide step: shift {rem,quo} left, trial-subtract B; borrow bit says restore
    always_comb begin
        rem_sh   = {rem, quo[DATA_WIDTH-1]};
        rem_diff = rem_sh - {2'b00, b_reg};
        trial_ok = ~rem_diff[DATA_WIDTH+1];
        quo_sh   = {quo[DATA_WIDTH-2:0], trial_ok};
    end

    // Result selection for the FINISH edge, including the divide-by-zero substitutes
    always_comb begin
        div_by_zero = op_reg[1] && (b_reg == '0);
        result_next = '0;
        case (op_reg)
            OP_MUL_LO: result_next = prod[DATA_WIDTH-1:0];
            OP_MUL_HI: result_next = prod[2*DATA_WIDTH-1:DATA_WIDTH];
            OP_DIV_Q:  result_next = div_by_zero ? {DATA_WIDTH{1'b1}} : quo;
            OP_DIV_R:  result_next = div_by_zero ? a_reg : rem[DATA_WIDTH-1:0];
            default:   result_next = '0;
        endcase
    end

    // Control FSM and datapath registers; FINISH is written after done_clr so it wins a tie
    always_ff @(posedge ACLK or posedge ARESET) begin
        if (ARESET) begin
            state  <= S_IDLE;
            cnt    <= '0;
            a_reg  <= '0;
            b_reg  <= '0;
            op_reg <= '0;
            prod   <= '0;
            rem    <= '0;
            quo    <= '0;
            result <= '0;
            busy   <= 1'b0;
            done   <= 1'b0;
            dbz    <= 1'b0;
        end else begin
            if (done_clr) begin
                done <= 1'b0;
                dbz  <= 1'b0;
            end
            case (state)
                S_IDLE: begin
                    if (start) begin
                        a_reg  <= op_a;
                        b_reg  <= op_b;
                        op_reg <= opcode;
                        prod   <= {{DATA_WIDTH{1'b0}}, op_a};
                        rem    <= '0;
                        quo    <= op_a;
                        cnt    <= '0;
                        busy   <= 1'b1;
                        done   <= 1'b0;
                        dbz    <= 1'b0;
                        state  <= (opcode[1] && (op_b == '0)) ? S_FINISH : S_CALC;
                    end
                end
                S_CALC: begin
                    cnt <= cnt + 1'b1;
                    if (op_reg[1]) begin
                        rem <= trial_ok ? rem_diff[DATA_WIDTH:0] : rem_sh[DATA_WIDTH:0];
                        quo <= quo_sh;
                    end else begin
                        prod <= prod_step;
                    end
                    if (cnt == LAST_ITER) begin
                        state <= S_FINISH;
                    end
                end
                S_FINISH: begin
                    result <= result_next;
                    done   <= 1'b1;
                    dbz    <= div_by_zero;
                    busy   <= 1'b0;
                    state  <= S_IDLE;
                end
                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_copro_core.sv
// tb/tb_copro_core.sv - directed scoreboard bench for copro_core
module tb_copro_core;

    logic        ACLK;
    logic        ARESET;
    logic        start;
    logic        done_clr;
    logic [1:0]  opcode;
    logic [31:0] op_a;
    logic [31:0] op_b;
    logic [31:0] result;
    logic        busy;
    logic        done;
    logic        dbz;

    int n_cmp = 0;
    int n_err = 0;

    typedef struct {
        logic [31:0] res;
        logic        dbz;
        int          lat;
    } exp_t;

    exp_t sb[$];

    copro_core #(.DATA_WIDTH(32)) dut (
        .ACLK     (ACLK),
        .ARESET   (ARESET),
        .start    (start),
        .done_clr (done_clr),
        .opcode   (opcode),
        .op_a     (op_a),
        .op_b     (op_b),
        .result   (result),
        .busy     (busy),
        .done     (done),
        .dbz      (dbz)
    );

    initial begin
        ACLK = 1'b0;
        forever #5 ACLK = ~ACLK;
    end

    task automatic tick();
        @(posedge ACLK);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic push_exp(input logic [31:0] a, input logic [31:0] b, input logic [1:0] op);
        exp_t        e;
        logic [63:0] p;
        p = 64'(a) * 64'(b);
        if (!op[1]) begin
            e.res = op[0] ? p[63:32] : p[31:0];
            e.dbz = 1'b0;
            e.lat = 33;
        end else if (b == 0) begin
            e.res = op[0] ? a : 32'hFFFF_FFFF;
            e.dbz = 1'b1;
            e.lat = 1;
        end else begin
            e.res = op[0] ? (a % b) : (a / b);
            e.dbz = 1'b0;
            e.lat = 33;
        end
        sb.push_back(e);
    endtask

    task automatic run_op(input logic [31:0] a, input logic [31:0] b, input logic [1:0] op,
                          input int inj_at, input int clr_at, input string tag);
        exp_t e;
        int   lat;
        int   busy_cnt;
        push_exp(a, b, op);
        op_a   = a;
        op_b   = b;
        opcode = op;
        start  = 1'b1;
        tick();
        start    = 1'b0;
        lat      = 0;
        busy_cnt = 0;
        while (!done && lat < 200) begin
            if (busy) busy_cnt++;
            if (lat == inj_at) begin
                op_a   = 32'd9;
                op_b   = 32'd9;
                opcode = 2'b00;
                start  = 1'b1;
            end
            if (lat == clr_at) done_clr = 1'b1;
            tick();
            start    = 1'b0;
            done_clr = 1'b0;
            lat++;
        end
        e = sb.pop_front();
        check({tag, " latency"}, 32'(lat), 32'(e.lat));
        check({tag, " busy_cycles"}, 32'(busy_cnt), 32'(e.lat));
        check({tag, " result"}, result, e.res);
        check({tag, " dbz"}, {31'b0, dbz}, {31'b0, e.dbz});
        check({tag, " done"}, {31'b0, done}, 32'd1);
        check({tag, " busy_low"}, {31'b0, busy}, 32'd0);
    endtask

    initial begin
        ARESET   = 1'b1;
        start    = 1'b0;
        done_clr = 1'b0;
        opcode   = 2'b00;
        op_a     = '0;
        op_b     = '0;
        tick();
        tick();
        check("reset result", result, 32'd0);
        check("reset busy", {31'b0, busy}, 32'd0);
        check("reset done", {31'b0, done}, 32'd0);
        check("reset dbz", {31'b0, dbz}, 32'd0);
        ARESET = 1'b0;
        tick();

        run_op(32'd7, 32'd6, 2'b00, -1, -1, "mul_lo_7x6");
        run_op(32'hFFFF_FFFF, 32'hFFFF_FFFF, 2'b01, -1, -1, "mul_hi_max");
        run_op(32'hFFFF_FFFF, 32'hFFFF_FFFF, 2'b00, -1, -1, "mul_lo_max");
        run_op(32'd100, 32'd7, 2'b10, -1, -1, "div_q_100_7");
        run_op(32'd100, 32'd7, 2'b11, -1, -1, "div_r_100_7");
        run_op(32'd5, 32'd0, 2'b10, -1, -1, "dbz_q");
        run_op(32'd5, 32'd0, 2'b11, -1, -1, "dbz_r");

        done_clr = 1'b1;
        tick();
        done_clr = 1'b0;
        check("done_clr done", {31'b0, done}, 32'd0);
        check("done_clr dbz", {31'b0, dbz}, 32'd0);
        check("done_clr result_held", result, 32'd5);

        run_op(32'd3, 32'd4, 2'b00, 10, -1, "start_while_busy");
        for (int i = 0; i < 3; i++) begin
            tick();
            check("no_requeue busy", {31'b0, busy}, 32'd0);
        end

        run_op(32'd1000, 32'd33, 2'b11, -1, 32, "finish_beats_clr");

        for (int i = 0; i < 4; i++) begin
            run_op($urandom, $urandom_range(1, 32'hFFFF), 2'($urandom_range(0, 3)), -1, -1, "random");
        end

        op_a   = 32'd100;
        op_b   = 32'd7;
        opcode = 2'b10;
        start  = 1'b1;
        tick();
        start = 1'b0;
        repeat (15) tick();
        #2 ARESET = 1'b1;
        #1;
        check("abort result", result, 32'd0);
        check("abort busy", {31'b0, busy}, 32'd0);
        check("abort done", {31'b0, done}, 32'd0);
        check("abort dbz", {31'b0, dbz}, 32'd0);
        tick();
        tick();
        ARESET = 1'b0;
        tick();
        check("post_abort busy", {31'b0, busy}, 32'd0);

        run_op(32'h0001_0000, 32'h0001_0000, 2'b01, -1, -1, "mul_hi_after_reset");

        check("scoreboard empty", 32'(sb.size()), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
